// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage.
//   - FUNCT3_* : load/store size and sign encodings
//   - state_e  : FSM state encoding (IDLE / REQ / WAIT)
//   - funct3_legal / addr_aligned : decode helpers used at accept time
package mem_access_pkg;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    // Loads accept LB/LH/LW/LBU/LHU; stores only SB/SH/SW.
    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        logic ok;
        case (f3)
            FUNCT3_LB, FUNCT3_LH, FUNCT3_LW: ok = 1'b1;
            FUNCT3_LBU, FUNCT3_LHU:          ok = ~is_store;
            default:                         ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Natural alignment by access size (f3[1:0]: 00 byte, 01 half, 10 word).
    function automatic logic addr_aligned(input logic [2:0] f3, input logic [1:0] lo);
        logic ok;
        case (f3[1:0])
            2'b00:   ok = 1'b1;
            2'b01:   ok = ~lo[0];
            2'b10:   ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane select and extension.
//   rdata  : full word returned by the data bus
//   off    : byte offset of the access inside the word
//   funct3 : load size/sign
//   data   : value to write back (sign- or zero-extended)
module load_align
    import mem_access_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted_s;

    // Move the addressed lane down to bit 0, then extend by access type.
    always_comb begin
        shifted_s = rdata >> {off, 3'b000};
        data      = rdata;
        case (funct3)
            FUNCT3_LB:  data = {{(XLEN-8){shifted_s[7]}},   shifted_s[7:0]};
            FUNCT3_LH:  data = {{(XLEN-16){shifted_s[15]}}, shifted_s[15:0]};
            FUNCT3_LBU: data = {{(XLEN-8){1'b0}},           shifted_s[7:0]};
            FUNCT3_LHU: data = {{(XLEN-16){1'b0}},          shifted_s[15:0]};
            FUNCT3_LW:  data = rdata;
            default:    data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory stage: takes execute results, performs byte/half/word loads and
// stores over a valid/ready data bus and produces a registered writeback.
//   in_valid/in_ready        : execute handshake (ready only while idle)
//   alu_result, store_data,
//   funct3, mem_read,
//   mem_write, rd, reg_write : captured instruction fields
//   dmem_req_*/dmem_addr/we/
//   be/wdata                 : bus request, held stable until accepted
//   dmem_rvalid/dmem_rdata   : load return
//   wb_valid/rd/we/data      : one-cycle writeback packet
//   err                      : one-cycle pulse on misaligned, illegal or
//                              timed-out access
// The store lane logic assumes a 32-bit datapath (4 byte lanes).
module mem_access
    import mem_access_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] store_data,
    input  logic [2:0]      funct3,
    input  logic            mem_read,
    input  logic            mem_write,
    input  logic [4:0]      rd,
    input  logic            reg_write,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic [XLEN-1:0] dmem_addr,
    output logic            dmem_we,
    output logic [3:0]      dmem_be,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rvalid,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic            wb_valid,
    output logic [4:0]      wb_rd,
    output logic            wb_we,
    output logic [XLEN-1:0] wb_data,
    output logic            err
);

    localparam int              CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W:0]  TIMEOUT_W = (CNT_W + 1)'(TIMEOUT);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [4:0]        rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              in_ready_q, in_ready_d;
    logic              req_valid_q, req_valid_d;
    logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
    logic              dmem_we_q, dmem_we_d;
    logic [3:0]        dmem_be_q, dmem_be_d;
    logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [4:0]        wb_rd_q, wb_rd_d;
    logic              wb_we_q, wb_we_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              err_q, err_d;

    logic [3:0]        be_s;
    logic [XLEN-1:0]   wdata_s;
    logic [XLEN-1:0]   load_data_s;
    logic [CNT_W:0]    cnt_inc_s;
    logic              timeout_hit_s;
    logic              is_mem_s;
    logic              bad_access_s;

    load_align #(.XLEN(XLEN)) u_load_align (
        .rdata  (dmem_rdata),
        .off    (addr_q[1:0]),
        .funct3 (funct3_q),
        .data   (load_data_s)
    );

    // Store byte enables and lane-replicated write data from the incoming op.
    always_comb begin
        be_s    = 4'b1111;
        wdata_s = store_data;
        case (funct3[1:0])
            2'b00: begin
                be_s    = 4'b0001 << alu_result[1:0];
                wdata_s = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_s    = alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{store_data[15:0]}};
            end
            default: begin
                be_s    = 4'b1111;
                wdata_s = store_data;
            end
        endcase
    end

    // Accept-time classification and timeout detection.
    always_comb begin
        is_mem_s      = mem_read | mem_write;
        bad_access_s  = (mem_read & mem_write)
                      | ~funct3_legal(mem_write, funct3)
                      | ~addr_aligned(funct3, alu_result[1:0]);
        // The counter value after this REQ/WAIT cycle; reaching TIMEOUT aborts.
        cnt_inc_s     = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
        timeout_hit_s = (cnt_inc_s >= TIMEOUT_W);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        funct3_d     = funct3_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        req_valid_d  = req_valid_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_we_d    = dmem_we_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_we_d      = 1'b0;
        wb_data_d    = wb_data_q;
        err_d        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready_q) begin
                    addr_d      = alu_result;
                    funct3_d    = funct3;
                    rd_d        = rd;
                    reg_write_d = reg_write;
                    cnt_d       = {CNT_W{1'b0}};
                    if (!is_mem_s) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        wb_we_d    = reg_write & (rd != 5'd0);
                        wb_data_d  = alu_result;
                    end else if (bad_access_s) begin
                        // Rejected without touching the bus.
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd;
                        wb_we_d    = 1'b0;
                        wb_data_d  = {XLEN{1'b0}};
                        err_d      = 1'b1;
                    end else begin
                        state_d      = ST_REQ;
                        req_valid_d  = 1'b1;
                        dmem_addr_d  = {alu_result[XLEN-1:2], 2'b00};
                        dmem_we_d    = mem_write;
                        dmem_be_d    = be_s;
                        dmem_wdata_d = wdata_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_REQ: begin
                cnt_d = cnt_inc_s[CNT_W-1:0];
                if (dmem_req_ready) begin
                    req_valid_d = 1'b0;
                    if (dmem_we_q) begin
                        state_d    = ST_IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_we_d    = 1'b0;
                        wb_data_d  = {XLEN{1'b0}};
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (timeout_hit_s) begin
                    state_d     = ST_IDLE;
                    req_valid_d = 1'b0;
                    wb_valid_d  = 1'b1;
                    wb_rd_d     = rd_q;
                    wb_data_d   = {XLEN{1'b0}};
                    err_d       = 1'b1;
                end else begin
                    state_d = ST_REQ;
                end
            end

            ST_WAIT: begin
                cnt_d = cnt_inc_s[CNT_W-1:0];
                if (dmem_rvalid) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_we_d    = reg_write_q & (rd_q != 5'd0);
                    wb_data_d  = load_data_s;
                end else if (timeout_hit_s) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = {XLEN{1'b0}};
                    err_d      = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                req_valid_d = 1'b0;
            end
        endcase

        in_ready_d = (state_d == ST_IDLE);
    end

    // State, captured fields and all outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= {CNT_W{1'b0}};
            addr_q       <= {XLEN{1'b0}};
            funct3_q     <= 3'b000;
            rd_q         <= 5'd0;
            reg_write_q  <= 1'b0;
            in_ready_q   <= 1'b1;
            req_valid_q  <= 1'b0;
            dmem_addr_q  <= {XLEN{1'b0}};
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= {XLEN{1'b0}};
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= 5'd0;
            wb_we_q      <= 1'b0;
            wb_data_q    <= {XLEN{1'b0}};
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            funct3_q     <= funct3_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            in_ready_q   <= in_ready_d;
            req_valid_q  <= req_valid_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_we_q    <= dmem_we_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_we_q      <= wb_we_d;
            wb_data_q    <= wb_data_d;
            err_q        <= err_d;
        end
    end

    assign in_ready       = in_ready_q;
    assign dmem_req_valid = req_valid_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_be        = dmem_be_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_rd          = wb_rd_q;
    assign wb_we          = wb_we_q;
    assign wb_data        = wb_data_q;
    assign err            = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT shortened to 8).
module tb_mem_access;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  rd;
    logic        reg_write;
    logic        dmem_req_valid;
    logic        dmem_req_ready;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_we;
    logic [31:0] wb_data;
    logic        err;

    int checks = 0;
    int errors = 0;

    mem_access #(.XLEN(32), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_result(alu_result), .store_data(store_data), .funct3(funct3),
        .mem_read(mem_read), .mem_write(mem_write), .rd(rd), .reg_write(reg_write),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
        .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_be(dmem_be),
        .dmem_wdata(dmem_wdata), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_we(wb_we), .wb_data(wb_data), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] sd;
        logic [2:0]  f3;
        logic        rdop;
        logic        wrop;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic        exp_err;
        logic        exp_we;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i, input logic [31:0] alu, input logic [31:0] sd,
                           input logic [2:0] f3, input logic rdop, input logic wrop,
                           input logic [4:0] r, input logic rw, input logic [31:0] rdata,
                           input logic exp_req, input logic [31:0] exp_addr,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic exp_err, input logic exp_we, input logic [31:0] exp_data);
        vecs[i] = '{alu, sd, f3, rdop, wrop, r, rw, rdata, exp_req, exp_addr,
                    exp_be, exp_wdata, exp_err, exp_we, exp_data};
    endtask

    task automatic drive_op(input logic [31:0] alu, input logic [31:0] sd, input logic [2:0] f3,
                            input logic rdop, input logic wrop, input logic [4:0] r, input logic rw);
        alu_result = alu; store_data = sd; funct3 = f3;
        mem_read = rdop; mem_write = wrop; rd = r; reg_write = rw;
        in_valid = 1'b1;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    // Apply one table vector; called at a negedge with the DUT idle.
    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        drive_op(v.alu, v.sd, v.f3, v.rdop, v.wrop, v.rd, v.rw);
        @(negedge clk);
        idle_inputs();
        if (v.exp_req) begin
            check($sformatf("v%0d req_valid", i), {31'd0, dmem_req_valid}, 32'd1);
            check($sformatf("v%0d in_ready", i), {31'd0, in_ready}, 32'd0);
            check($sformatf("v%0d dmem_addr", i), dmem_addr, v.exp_addr);
            check($sformatf("v%0d dmem_we", i), {31'd0, dmem_we}, {31'd0, v.wrop});
            if (v.wrop) begin
                check($sformatf("v%0d dmem_be", i), {28'd0, dmem_be}, {28'd0, v.exp_be});
                check($sformatf("v%0d dmem_wdata", i), dmem_wdata, v.exp_wdata);
            end
            dmem_req_ready = 1'b1;
            @(negedge clk);
            dmem_req_ready = 1'b0;
            if (!v.wrop) begin
                check($sformatf("v%0d early wb", i), {31'd0, wb_valid}, 32'd0);
                dmem_rvalid = 1'b1;
                dmem_rdata  = v.rdata;
                @(negedge clk);
                dmem_rvalid = 1'b0;
            end
        end
        check($sformatf("v%0d wb_valid", i), {31'd0, wb_valid}, 32'd1);
        check($sformatf("v%0d err", i), {31'd0, err}, {31'd0, v.exp_err});
        check($sformatf("v%0d wb_we", i), {31'd0, wb_we}, {31'd0, v.exp_we});
        check($sformatf("v%0d wb_rd", i), {27'd0, wb_rd}, {27'd0, v.rd});
        check($sformatf("v%0d req_valid off", i), {31'd0, dmem_req_valid}, 32'd0);
        if (!v.exp_err && !v.wrop)
            check($sformatf("v%0d wb_data", i), wb_data, v.exp_data);
        @(negedge clk);
        check($sformatf("v%0d wb pulse", i), {30'd0, wb_valid, err}, 32'd0);
    endtask

    initial begin
        int n;
        int wbs;
        rst_n = 1'b0; dmem_req_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'd0;
        alu_result = 32'd0; store_data = 32'd0; funct3 = 3'd0; rd = 5'd0; reg_write = 1'b0;
        idle_inputs();

        //         alu           sd            f3      rd    wr    rd     rw    rdata         req   addr          be       wdata         err   we    data
        set_vec(0,  32'h0000_1234, 32'h0,        3'b000, 1'b0, 1'b0, 5'd5,  1'b1, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b0, 1'b1, 32'h0000_1234);
        set_vec(1,  32'h0000_DEAD, 32'h0,        3'b000, 1'b0, 1'b0, 5'd0,  1'b1, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b0, 1'b0, 32'h0000_DEAD);
        set_vec(2,  32'h0000_0103, 32'h0000_00AB, 3'b000, 1'b0, 1'b1, 5'd1,  1'b0, 32'h0,        1'b1, 32'h0000_0100, 4'b1000, 32'hABAB_ABAB, 1'b0, 1'b0, 32'h0);
        set_vec(3,  32'h0000_0202, 32'h1234_BEEF, 3'b001, 1'b0, 1'b1, 5'd2,  1'b0, 32'h0,        1'b1, 32'h0000_0200, 4'b1100, 32'hBEEF_BEEF, 1'b0, 1'b0, 32'h0);
        set_vec(4,  32'h0000_0300, 32'hCAFE_F00D, 3'b010, 1'b0, 1'b1, 5'd3,  1'b0, 32'h0,        1'b1, 32'h0000_0300, 4'b1111, 32'hCAFE_F00D, 1'b0, 1'b0, 32'h0);
        set_vec(5,  32'h0000_0102, 32'h0,        3'b000, 1'b1, 1'b0, 5'd7,  1'b1, 32'h0080_0000, 1'b1, 32'h0000_0100, 4'h0,    32'h0,        1'b0, 1'b1, 32'hFFFF_FF80);
        set_vec(6,  32'h0000_0102, 32'h0,        3'b100, 1'b1, 1'b0, 5'd7,  1'b1, 32'h0080_0000, 1'b1, 32'h0000_0100, 4'h0,    32'h0,        1'b0, 1'b1, 32'h0000_0080);
        set_vec(7,  32'h0000_0106, 32'h0,        3'b001, 1'b1, 1'b0, 5'd8,  1'b1, 32'h8001_1234, 1'b1, 32'h0000_0104, 4'h0,    32'h0,        1'b0, 1'b1, 32'hFFFF_8001);
        set_vec(8,  32'h0000_0104, 32'h0,        3'b101, 1'b1, 1'b0, 5'd9,  1'b1, 32'h8001_F234, 1'b1, 32'h0000_0104, 4'h0,    32'h0,        1'b0, 1'b1, 32'h0000_F234);
        set_vec(9,  32'h0000_010C, 32'h0,        3'b010, 1'b1, 1'b0, 5'd3,  1'b1, 32'h89AB_CDEF, 1'b1, 32'h0000_010C, 4'h0,    32'h0,        1'b0, 1'b1, 32'h89AB_CDEF);
        set_vec(10, 32'h0000_0101, 32'h0,        3'b000, 1'b1, 1'b0, 5'd0,  1'b1, 32'h1234_567F, 1'b1, 32'h0000_0100, 4'h0,    32'h0,        1'b0, 1'b0, 32'h0000_0056);
        set_vec(11, 32'h0000_0102, 32'h0,        3'b010, 1'b1, 1'b0, 5'd4,  1'b1, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b1, 1'b0, 32'h0);
        set_vec(12, 32'h0000_0101, 32'h0,        3'b001, 1'b0, 1'b1, 5'd4,  1'b0, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b1, 1'b0, 32'h0);
        set_vec(13, 32'h0000_0100, 32'h0,        3'b011, 1'b1, 1'b0, 5'd4,  1'b1, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b1, 1'b0, 32'h0);
        set_vec(14, 32'h0000_0100, 32'h0,        3'b100, 1'b0, 1'b1, 5'd4,  1'b0, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b1, 1'b0, 32'h0);
        set_vec(15, 32'h0000_0100, 32'h0,        3'b010, 1'b1, 1'b1, 5'd4,  1'b1, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b1, 1'b0, 32'h0);
        set_vec(16, 32'h0000_0103, 32'h0,        3'b101, 1'b1, 1'b0, 5'd4,  1'b1, 32'h0,        1'b0, 32'h0,        4'h0,    32'h0,        1'b1, 1'b0, 32'h0);

        // Reset values.
        repeat (2) @(negedge clk);
        check("rst in_ready", {31'd0, in_ready}, 32'd1);
        check("rst outputs", {26'd0, dmem_req_valid, dmem_we, wb_valid, wb_we, err, 1'b0}, 32'd0);
        check("rst buses", dmem_addr | dmem_wdata | wb_data | {23'd0, wb_rd, dmem_be}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 17; i++) run_vec(i);

        // Stalled LW: ready low 3 cycles, rvalid two cycles after handshake,
        // then a back-to-back ADD accepted in the writeback cycle.
        drive_op(32'h0000_0208, 32'h0, 3'b010, 1'b1, 1'b0, 5'd6, 1'b1);
        @(negedge clk);
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("stall req_valid %0d", k), {31'd0, dmem_req_valid}, 32'd1);
            check($sformatf("stall in_ready %0d", k), {31'd0, in_ready}, 32'd0);
            @(negedge clk);
        end
        check("stall addr", dmem_addr, 32'h0000_0208);
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        check("wait req dropped", {31'd0, dmem_req_valid}, 32'd0);
        check("wait in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("wait in_ready 2", {30'd0, in_ready, wb_valid}, 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'h1357_9BDF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        check("stall wb_valid", {31'd0, wb_valid}, 32'd1);
        check("stall wb_data", wb_data, 32'h1357_9BDF);
        check("stall wb_rd", {27'd0, wb_rd}, 32'd6);
        check("stall in_ready back", {31'd0, in_ready}, 32'd1);
        drive_op(32'h0000_0055, 32'h0, 3'b000, 1'b0, 1'b0, 5'd9, 1'b1);
        @(negedge clk);
        idle_inputs();
        check("b2b wb_valid", {31'd0, wb_valid}, 32'd1);
        check("b2b wb_data", wb_data, 32'h0000_0055);
        check("b2b wb_rd", {27'd0, wb_rd}, 32'd9);
        wbs = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (wb_valid) wbs++;
        end
        check("b2b single wb", wbs, 32'd0);

        // Timeout: request never accepted.
        drive_op(32'h0000_0400, 32'h0, 3'b010, 1'b1, 1'b0, 5'd2, 1'b1);
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (dmem_req_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("timeout req cycles", n, 32'd8);
        check("timeout err", {31'd0, err}, 32'd1);
        check("timeout wb", {30'd0, wb_valid, wb_we}, 32'd2);
        check("timeout in_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("timeout err pulse", {31'd0, err}, 32'd0);

        // Reset while waiting for load data, then a stray rvalid.
        drive_op(32'h0000_0500, 32'h0, 3'b010, 1'b1, 1'b0, 5'd3, 1'b1);
        @(negedge clk);
        idle_inputs();
        dmem_req_ready = 1'b1;
        @(negedge clk);
        dmem_req_ready = 1'b0;
        check("rst-wait in WAIT", {30'd0, in_ready, dmem_req_valid}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check("rst-wait in_ready", {31'd0, in_ready}, 32'd1);
        check("rst-wait outputs", {27'd0, dmem_req_valid, dmem_we, wb_valid, wb_we, err}, 32'd0);
        check("rst-wait buses", dmem_addr | wb_data | {27'd0, wb_rd}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        dmem_rvalid = 1'b0;
        wbs = 0;
        for (int k = 0; k < 3; k++) begin
            if (wb_valid || err) wbs++;
            @(negedge clk);
        end
        check("stray rvalid no wb", wbs, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
